// File: rtl/v_pkg.sv
// Shared encodings for the vector issue path: opcodes, operand-type fields,
// memory addressing modes, unit indices and the issue FSM state type.
package v_pkg;

  localparam logic [6:0] OPC_LTYPE = 7'b0000111;
  localparam logic [6:0] OPC_STYPE = 7'b0100111;
  localparam logic [6:0] OPC_RTYPE = 7'b1010111;

  localparam logic [2:0] OPI_VV = 3'b000;
  localparam logic [2:0] OPM_VV = 3'b010;
  localparam logic [2:0] OPI_VI = 3'b011;
  localparam logic [2:0] OPI_VX = 3'b100;
  localparam logic [2:0] OPM_VX = 3'b110;

  localparam logic [1:0] MOP_UNIT    = 2'b00;
  localparam logic [1:0] MOP_IDX_UO  = 2'b01;
  localparam logic [1:0] MOP_STRIDED = 2'b10;
  localparam logic [1:0] MOP_IDX_O   = 2'b11;

  localparam logic [5:0] F6_SLIDEUP   = 6'b001110;
  localparam logic [5:0] F6_SLIDEDOWN = 6'b001111;

  localparam int unsigned NUM_UNITS = 5;
  localparam logic [2:0] U_ALU  = 3'd0;
  localparam logic [2:0] U_MUL  = 3'd1;
  localparam logic [2:0] U_LSU  = 3'd2;
  localparam logic [2:0] U_SLDU = 3'd3;
  localparam logic [2:0] U_RED  = 3'd4;

  typedef enum logic [1:0] {IDLE, CHECK, ISSUE} iss_state_e;

  function automatic logic opc_legal(input logic [6:0] opc);
    return (opc == OPC_LTYPE) || (opc == OPC_STYPE) || (opc == OPC_RTYPE);
  endfunction

  function automatic logic mop_indexed(input logic [1:0] mop);
    return (mop == MOP_IDX_UO) || (mop == MOP_IDX_O);
  endfunction

endpackage

// File: rtl/v_decoder.sv
// Pure field extraction from a 32-bit vector instruction word.
module v_decoder (
  input  logic [31:0] instr_i,
  output logic [6:0]  opcode_o,
  output logic [2:0]  funct3_o,
  output logic [5:0]  funct6_o,
  output logic [1:0]  mop_o,
  output logic [4:0]  vd_o,
  output logic [4:0]  vs1_o,
  output logic [4:0]  vs2_o,
  output logic [4:0]  imm_o,
  output logic [4:0]  rs2_o
);

  assign opcode_o = instr_i[6:0];
  assign vd_o     = instr_i[11:7];
  assign funct3_o = instr_i[14:12];
  assign vs1_o    = instr_i[19:15];
  assign imm_o    = instr_i[19:15];
  assign vs2_o    = instr_i[24:20];
  assign rs2_o    = instr_i[24:20];
  assign mop_o    = instr_i[27:26];
  assign funct6_o = instr_i[31:26];

endmodule

// File: rtl/v_issue_ctrl.sv
// Single-issue vector dispatch: decode, unit select, scoreboard/busy stall,
// one-cycle start pulse, and per-unit retirement on done.
module v_issue_ctrl #(
  parameter int unsigned NUM_VREG    = 32,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   instr_valid,
  input  logic [31:0]            instr,
  output logic                   instr_ready,
  input  logic [4:0]             unit_busy,
  input  logic [4:0]             unit_done,
  output logic [4:0]             unit_start,
  output logic [5:0]             iss_op,
  output logic [2:0]             iss_funct3,
  output logic [4:0]             iss_vd,
  output logic [4:0]             iss_vrs1,
  output logic [4:0]             iss_vrs2,
  output logic [4:0]             iss_imm,
  output logic [4:0]             iss_rs2,
  output logic                   illegal,
  output logic [NUM_VREG-1:0]    sb_busy,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  import v_pkg::*;

  iss_state_e              state_q;
  logic [31:0]             instr_q;
  logic                    ready_q, illegal_q;
  logic [4:0]              start_q;
  logic [5:0]              op_q;
  logic [2:0]              f3_q;
  logic [4:0]              vd_q, vrs1_q, vrs2_q, imm_q, rs2_q;
  logic [STALL_CNT_W-1:0]  stall_q;

  logic [NUM_VREG-1:0]              sb_q, sb_d;
  logic [NUM_UNITS-1:0]             pend_q, pend_d, wr_q, wr_d;
  logic [NUM_UNITS-1:0][4:0]        pvd_q, pvd_d;

  logic [6:0] d_opc;
  logic [2:0] d_f3;
  logic [5:0] d_f6;
  logic [1:0] d_mop;
  logic [4:0] d_vd, d_vs1, d_vs2, d_imm, d_rs2;

  logic       is_ld, is_st, is_r, hazard, can_issue;
  logic [2:0] sel;

  v_decoder u_dec (
    .instr_i  (instr_q),
    .opcode_o (d_opc),
    .funct3_o (d_f3),
    .funct6_o (d_f6),
    .mop_o    (d_mop),
    .vd_o     (d_vd),
    .vs1_o    (d_vs1),
    .vs2_o    (d_vs2),
    .imm_o    (d_imm),
    .rs2_o    (d_rs2)
  );

  always_comb begin
    is_ld = (d_opc == OPC_LTYPE);
    is_st = (d_opc == OPC_STYPE);
    is_r  = (d_opc == OPC_RTYPE);

    sel = U_ALU;
    if (is_ld || is_st)
      sel = U_LSU;
    else if (d_f3 == OPM_VX)
      sel = U_RED;
    else if ((d_f3 == OPM_VV) && (d_f6[5:3] == 3'b100))
      sel = U_MUL;
    else if (((d_f3 == OPI_VV) || (d_f3 == OPI_VX) || (d_f3 == OPI_VI)) &&
             ((d_f6 == F6_SLIDEUP) || (d_f6 == F6_SLIDEDOWN)))
      sel = U_SLDU;

    // Stores read vd as data; loads and R-type write vd (WAW).
    hazard = 1'b0;
    if (is_r) begin
      hazard = sb_q[d_vs2];
      if ((d_f3 == OPI_VV) || (d_f3 == OPM_VV))
        hazard = hazard | sb_q[d_vs1];
    end
    if ((is_ld || is_st) && mop_indexed(d_mop))
      hazard = hazard | sb_q[d_vs2];
    if ((is_st || is_ld || is_r) && sb_q[d_vd])
      hazard = 1'b1;

    can_issue = (state_q == CHECK) && !hazard && !unit_busy[sel] && !pend_q[sel];
  end

  // Retire first, then record the issuing op so a same-cycle set wins.
  always_comb begin
    sb_d   = sb_q;
    pend_d = pend_q;
    wr_d   = wr_q;
    pvd_d  = pvd_q;
    for (int unsigned u = 0; u < NUM_UNITS; u++) begin
      if (unit_done[u] && pend_q[u]) begin
        pend_d[u] = 1'b0;
        if (wr_q[u])
          sb_d[pvd_q[u]] = 1'b0;
      end
    end
    if (state_q == ISSUE) begin
      pend_d[sel] = 1'b1;
      pvd_d[sel]  = d_vd;
      wr_d[sel]   = !is_st;
      if (!is_st)
        sb_d[d_vd] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sb_q   <= '0;
      pend_q <= '0;
      wr_q   <= '0;
      pvd_q  <= '0;
    end else begin
      sb_q   <= sb_d;
      pend_q <= pend_d;
      wr_q   <= wr_d;
      pvd_q  <= pvd_d;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      instr_q   <= '0;
      ready_q   <= 1'b1;
      illegal_q <= 1'b0;
      start_q   <= '0;
      op_q      <= '0;
      f3_q      <= '0;
      vd_q      <= '0;
      vrs1_q    <= '0;
      vrs2_q    <= '0;
      imm_q     <= '0;
      rs2_q     <= '0;
      stall_q   <= '0;
    end else begin
      start_q   <= '0;
      illegal_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (instr_valid && ready_q) begin
            if (opc_legal(instr[6:0])) begin
              instr_q <= instr;
              ready_q <= 1'b0;
              state_q <= CHECK;
            end else begin
              illegal_q <= 1'b1;
            end
          end
        end
        CHECK: begin
          if (can_issue) begin
            start_q <= 5'b00001 << sel;
            op_q    <= d_f6;
            f3_q    <= d_f3;
            vd_q    <= d_vd;
            vrs1_q  <= d_vs1;
            vrs2_q  <= d_vs2;
            imm_q   <= d_imm;
            rs2_q   <= d_rs2;
            state_q <= ISSUE;
          end else if (stall_q != '1) begin
            stall_q <= stall_q + STALL_CNT_W'(1);
          end
        end
        ISSUE: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign instr_ready  = ready_q;
  assign illegal      = illegal_q;
  assign unit_start   = start_q;
  assign iss_op       = op_q;
  assign iss_funct3   = f3_q;
  assign iss_vd       = vd_q;
  assign iss_vrs1     = vrs1_q;
  assign iss_vrs2     = vrs2_q;
  assign iss_imm      = imm_q;
  assign iss_rs2      = rs2_q;
  assign sb_busy      = sb_q;
  assign stall_cycles = stall_q;

endmodule
